// File: rtl/rr_stream_mux.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin arbitration.
// Optional transfer counter port xfer_cnt is enabled by defining RR_STREAM_MUX_STATS_EN.
module rr_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [CH_W-1:0]          sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch
`ifdef RR_STREAM_MUX_STATS_EN
    ,
    output logic [15:0]              xfer_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     g_idx;
    logic                found;
    logic                load_en;
    logic                in_xfer;
    int                  idx;
    int                  sel_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant scan: fixed select, or first valid channel starting at ptr with wraparound.
    always_comb begin
        grant   = '0;
        g_idx   = '0;
        found   = 1'b0;
        idx     = 0;
        sel_int = int'(sel);
        if (!mode) begin
            if (sel_int < NUM_CH && in_valid[sel]) begin
                found = 1'b1;
                g_idx = sel;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && in_valid[idx[CH_W-1:0]]) begin
                    found = 1'b1;
                    g_idx = idx[CH_W-1:0];
                end
            end
        end
        if (found) grant[g_idx] = 1'b1;
    end

    assign load_en  = (state_q == EMPTY) || out_ready;
    assign in_xfer  = rst_n && load_en && found;
    assign in_ready = in_xfer ? grant : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = FULL;
            FULL:    if (!in_xfer && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        ptr_d  = ptr_q;
        if (in_xfer) begin
            data_d = in_data[g_idx*DATA_W +: DATA_W];
            ch_d   = g_idx;
            if (mode) ptr_d = (g_idx == CH_W'(NUM_CH - 1)) ? '0 : g_idx + CH_W'(1);
        end
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_ch    = ch_q;
    end

`ifdef RR_STREAM_MUX_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Saturating count of words accepted by the consumer.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed scenarios plus random traffic against a
// cycle-level reference model of the output register and arbiter pointer.
module tb_rr_stream_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic                     mode = 1'b0;
    logic [CH_W-1:0]          sel = '0;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [CH_W-1:0]          out_ch;
`ifdef RR_STREAM_MUX_STATS_EN
    logic [15:0]              xfer_cnt;
`endif

    rr_stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef RR_STREAM_MUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit       m_valid;
    int       m_data;
    int       m_ch;
    int       m_ptr;
    int       m_cnt;
    int       cnt0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
    endtask

    function automatic int model_grant();
        if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle with current inputs: check at negedge, advance model at posedge.
    task automatic cycle();
        int g;
        bit ld;
        bit out_x;
        logic [NUM_CH-1:0] exp_rdy;
        g  = model_grant();
        ld = !m_valid || out_ready;
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_ch", 32'(out_ch), 32'(m_ch));
        end
`ifdef RR_STREAM_MUX_STATS_EN
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
        @(posedge clk);
        out_x = m_valid && out_ready;
        if (out_x && m_cnt < 65535) m_cnt++;
        if (ld && g >= 0) begin
            m_valid = 1;
            m_data  = int'(in_data[g*DATA_W +: DATA_W]);
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % NUM_CH;
        end else if (out_x) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset with all channels valid
        in_valid  = 4'hF;
        in_data   = 32'hDEADBEEF;
        mode      = 1'b1;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rr_first_grant", 32'(in_ready), 32'h1);
        cycle();
        #1;
        check("rr_first_ch", 32'(out_ch), 32'd0);

        // Fixed select
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0111; in_data = 32'h44332211; out_ready = 1'b1;
        #1;
        check("fix_ready", 32'(in_ready), 32'h4);
        cycle();
        #1;
        check("fix_data", 32'(out_data), 32'h33);
        check("fix_ch", 32'(out_ch), 32'd2);

        // Fixed select on a channel that is not valid
        sel = 2'd3;
        #1;
        check("fix_nogrant", 32'(in_ready), 32'h0);
        cycle();
        #1;
        check("fix_drain", 32'(out_valid), 32'd0);

        // Round-robin, all valid
        do_reset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = $urandom;
            cycle();
            #1;
            check("rr_seq_ch", 32'(out_ch), 32'(i % NUM_CH));
            check("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Round-robin skip from ptr=1
        do_reset();
        mode = 1'b1; in_valid = 4'b0001; in_data = $urandom;
        cycle();
        in_valid = 4'b1001;
        cycle();
        #1;
        check("rr_skip_3", 32'(out_ch), 32'd3);
        cycle();
        #1;
        check("rr_skip_0", 32'(out_ch), 32'd0);

        // Backpressure
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h000000A5; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; in_valid = 4'hF; in_data = 32'h5A5A5A5A;
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            cycle();
            #1;
            check("bp_data", 32'(out_data), 32'hA5);
            check("bp_ready", 32'(in_ready), 32'h0);
`ifdef RR_STREAM_MUX_STATS_EN
            check("bp_cnt_hold", 32'(xfer_cnt), 32'(cnt0));
`endif
        end
        out_ready = 1'b1;
        cycle();
`ifdef RR_STREAM_MUX_STATS_EN
        check("bp_cnt_inc", 32'(xfer_cnt), 32'(cnt0 + 1));
`endif

        // Reset asserted mid-stream
        mode = 1'b1; in_valid = 4'b0100; in_data = 32'h00770000;
        cycle();
        rst_n = 1'b0;
        #2;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        in_valid = 4'hF;
        #1;
        check("midrst_ptr", 32'(in_ready), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom_range(0, 15));
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
